instr_fetch_unit: RTL and testbench

- Fetch stage of the single-cycle RISC-V core. It sits directly upstream of the controller and feeds it opcode, func3 and func7.
- Owns the PC and issues word requests to instruction memory over a request/grant/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Consumes the controller's PCSrc as a redirect: the unit flushes and refetches from the target.

---
 rtl/instr_fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the single-cycle RISC-V core. Owns the program counter,
// issues one word fetch at a time to instruction memory, buffers the returned
// words in a small FIFO and hands them to decode over a valid/ready handshake.
// A redirect from the controller (PCSrc) flushes the buffer and restarts
// fetching at the target. A response that is still in flight when the
// redirect arrives is drained and discarded.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and word address (bits [1:0] always 0)
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   single-cycle response pulse and instruction word
//   redirect_valid/pc   taken branch / jump target from the controller
//   id_valid/id_ready   buffer head handshake towards decode
//   id_instr/id_pc      head instruction (NOP when empty) and its PC (0 when empty)
//   opcode/func3/func7  fixed bit fields of id_instr for the controller
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic [XLEN-1:0]   buf_instr_q [BUF_DEPTH];
    logic [XLEN-1:0]   buf_instr_d [BUF_DEPTH];
    logic [XLEN-1:0]   buf_pc_q    [BUF_DEPTH];
    logic [XLEN-1:0]   buf_pc_d    [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic granted;
    logic push;
    logic pop;
    logic flush;

    // A request is only made from S_RUN, where nothing is outstanding, so the
    // free-slot test reduces to the buffer count alone. Reserving the slot at
    // grant time guarantees the eventual push never finds the buffer full.
    assign imem_req  = (state_q == S_RUN) && !redirect_valid &&
                       (count_q < CNT_W'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign granted   = imem_req && imem_gnt;

    assign id_valid  = (count_q != '0);
    assign id_instr  = id_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
    assign id_pc     = id_valid ? buf_pc_q[rd_ptr_q]    : '0;
    assign opcode    = id_instr[6:0];
    assign func3     = id_instr[14:12];
    assign func7     = id_instr[31:25];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        push      = 1'b0;
        pop       = id_valid && id_ready;
        flush     = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (granted) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + XLEN'(4);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above. A response that arrives in the
        // same cycle as the redirect is simply dropped; waiting for another one
        // would hang, so only a still-pending response sends us to S_DRAIN.
        if (redirect_valid) begin
            pc_d  = redirect_pc & ~XLEN'(3);
            push  = 1'b0;
            pop   = 1'b0;
            flush = 1'b1;
            if ((state_q == S_WAIT && !imem_rvalid) || granted) begin
                state_d = S_DRAIN;
            end else if (state_q == S_DRAIN && !imem_rvalid) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_RUN;
            end
        end
    end

    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_rdata;
                buf_pc_d[wr_ptr_q]    = pend_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A small behavioural memory grants
// under bench control and answers after a programmable latency with a word
// derived from the address, so every popped instruction can be checked
// against the PC it was fetched from.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    int          check_count = 0;
    int          fail_count  = 0;
    int          grant_count = 0;
    int          latency     = 1;
    int          rv_cnt      = 0;
    logic        g_seen      = 1'b0;
    logic [31:0] g_addr      = '0;
    logic [31:0] rv_addr     = '0;
    logic [31:0] pop_q [$];

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr << 5) ^ 32'hC0DE_5013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                 input logic gnt, input logic rdy);
        @(posedge clk);
        #1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = gnt;
        id_ready       = rdy;
    endtask

    task automatic applyReset(input logic gnt, input logic rdy, input int lat);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = gnt;
        id_ready       = rdy;
        latency        = lat;
        repeat (2) @(posedge clk);
        #1;
        pop_q.delete();
        grant_count = 0;
        rst_n       = 1'b1;
    endtask

    task automatic waitPopCount(input int n, input string tag);
        for (int c = 0; c < 80; c++) begin
            if (pop_q.size() >= n) break;
            @(negedge clk);
        end
        if (pop_q.size() < n) checkOutput(tag, pop_q.size(), n);
    endtask

    task automatic waitGrant(input logic match_addr, input logic [31:0] addr,
                             input string tag);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && (!match_addr || imem_addr == addr)) found = 1'b1;
        end
        checkOutput(tag, {31'd0, found}, 32'd1);
    endtask

    // Memory model: grants are sampled mid-cycle, responses are driven just
    // after the rising edge so the DUT sees them for one whole cycle.
    always @(negedge clk) begin
        g_seen = rst_n && imem_req && imem_gnt;
        g_addr = imem_addr;
        if (g_seen) grant_count++;
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(rv_addr);
            end
        end
        if (g_seen) begin
            if (latency <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(g_addr);
            end else begin
                rv_cnt  = latency - 1;
                rv_addr = g_addr;
            end
        end
    end

    // Decode-side monitor: every consumed instruction must be the word stored
    // at the PC reported with it.
    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready && !redirect_valid) begin
            pop_q.push_back(id_pc);
            checkOutput("instr_of_pc", id_instr, memWord(id_pc));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] w;
        int          first_c;

        // Reset state
        @(negedge clk);
        checkOutput("rst_req",      {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr",     imem_addr, 32'h0000_0000);
        checkOutput("rst_id_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("rst_id_instr", id_instr, 32'h0000_0013);
        checkOutput("rst_id_pc",    id_pc, 32'h0000_0000);

        // Streaming fetch from reset, immediate grant, 1-cycle latency
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        first_c = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (id_valid) begin
                first_c = c;
                break;
            end
        end
        checkOutput("first_valid_cycle", {31'd0, (first_c >= 3 && first_c <= 20)}, 32'd1);
        w = memWord(32'h0);
        checkOutput("first_id_pc", id_pc, 32'h0);
        checkOutput("opcode", {25'd0, opcode}, {25'd0, w[6:0]});
        checkOutput("func3",  {29'd0, func3},  {29'd0, w[14:12]});
        checkOutput("func7",  {25'd0, func7},  {25'd0, w[31:25]});
        waitPopCount(4, "stream_timeout");
        checkOutput("stream_pc0", pop_q[0], 32'h0);
        checkOutput("stream_pc1", pop_q[1], 32'h4);
        checkOutput("stream_pc2", pop_q[2], 32'h8);
        checkOutput("stream_pc3", pop_q[3], 32'hC);

        // Decode stalled: buffer fills to two and fetching stops
        applyReset(1'b1, 1'b0, 1);
        repeat (10) @(negedge clk);
        checkOutput("stall_grants",   grant_count, 32'd2);
        checkOutput("stall_id_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("stall_id_pc",    id_pc, 32'h0);
        checkOutput("stall_id_instr", id_instr, memWord(32'h0));
        checkOutput("stall_req",      {31'd0, imem_req}, 32'd0);
        checkOutput("stall_addr",     imem_addr, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitPopCount(3, "stall_drain_timeout");
        checkOutput("stall_pop0", pop_q[0], 32'h0);
        checkOutput("stall_pop1", pop_q[1], 32'h4);
        checkOutput("stall_pop2", pop_q[2], 32'h8);

        // Redirect to 0x100 while the 0x10 fetch is outstanding (3-cycle latency)
        applyReset(1'b1, 1'b1, 3);
        waitGrant(1'b1, 32'h10, "grant_0x10");
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("redir_req_low", {31'd0, imem_req}, 32'd0);
        pop_q.delete();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("redir_flushed",  {31'd0, id_valid}, 32'd0);
        checkOutput("redir_drain_req", {31'd0, imem_req}, 32'd0);
        checkOutput("redir_addr",     imem_addr, 32'h100);
        waitPopCount(1, "redir_timeout");
        checkOutput("redir_first_pc", pop_q[0], 32'h100);

        // Grant withheld for five cycles: request and address hold steady
        applyReset(1'b0, 1'b1, 1);
        for (int c = 0; c < 10 && !imem_req; c++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_req",  {31'd0, imem_req}, 32'd1);
            checkOutput("hold_addr", imem_addr, 32'h0);
            @(negedge clk);
        end
        grant_count = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("hold_one_grant", grant_count, 32'd1);
        checkOutput("hold_next_addr", imem_addr, 32'h4);
        checkOutput("hold_pops",      pop_q.size(), 32'd1);
        checkOutput("hold_pop0",      pop_q[0], 32'h0);

        // Redirect to 0x202 in a cycle where the memory offers a grant
        applyStimulus(1'b1, 32'h202, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("gnt_redir_req_low", {31'd0, imem_req}, 32'd0);
        pop_q.delete();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("gnt_redir_addr",  imem_addr, 32'h200);
        checkOutput("gnt_redir_empty", {31'd0, id_valid}, 32'd0);
        waitPopCount(1, "gnt_redir_timeout");
        checkOutput("gnt_redir_first_pc", pop_q[0], 32'h200);

        // PC wrap past the top of the address space
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        @(negedge clk);
        pop_q.delete();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        waitPopCount(2, "wrap_timeout");
        checkOutput("wrap_pc0", pop_q[0], 32'hFFFF_FFFC);
        checkOutput("wrap_pc1", pop_q[1], 32'h0000_0000);

        // Reset pulse while a 3-cycle fetch is in flight
        latency = 3;
        waitGrant(1'b0, 32'h0, "grant_before_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_id_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("midrst_req",      {31'd0, imem_req}, 32'd0);
        checkOutput("midrst_addr",     imem_addr, 32'h0);
        pop_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitPopCount(1, "midrst_timeout");
        checkOutput("midrst_first_pc", pop_q[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
